// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard/stall control: combinational stage enables from a 4-state FSM, zero-latency release on dmem_ack.
// Optional stall-cycle performance counter is built only when STALL_PERF_CNT_EN is defined.
module pipeline_stall_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned PERF_W         = 16
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              load_use_hazard,
   input  logic              branch_taken,
   input  logic              dmem_req,
   input  logic              dmem_ack,
   output logic              pc_write_en,
   output logic              if_id_write_en,
   output logic              if_id_flush,
   output logic              id_ex_bubble,
   output logic              ex_mem_write_en,
   output logic              mem_wb_bubble,
   output logic              stall_active,
   output logic              timeout_err,
   output logic [PERF_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2,
      ERR        = 2'd3
   } state_e;

   localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);

   state_e     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;

   logic pc_we, if_id_we, if_id_fl, id_ex_bub, ex_mem_we, mem_wb_bub, terr;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      pc_we      = 1'b1;
      if_id_we   = 1'b1;
      if_id_fl   = 1'b0;
      id_ex_bub  = 1'b0;
      ex_mem_we  = 1'b1;
      mem_wb_bub = 1'b0;
      terr       = 1'b0;

      case (state_q)
         RUN, LOAD_STALL: begin
            if (dmem_req && !dmem_ack) begin
               pc_we      = 1'b0;
               if_id_we   = 1'b0;
               ex_mem_we  = 1'b0;
               mem_wb_bub = 1'b1;
               wait_cnt_d = 8'd1;
               state_d    = MEM_WAIT;
            end else if (branch_taken) begin
               if_id_fl  = 1'b1;
               id_ex_bub = 1'b1;
               state_d   = RUN;
            end else if (load_use_hazard && (state_q == RUN)) begin
               // Second cycle of a held hazard is the one LOAD_STALL lets through.
               pc_we     = 1'b0;
               if_id_we  = 1'b0;
               id_ex_bub = 1'b1;
               state_d   = LOAD_STALL;
            end else begin
               state_d = RUN;
            end
         end

         MEM_WAIT: begin
            if (!dmem_ack) begin
               pc_we      = 1'b0;
               if_id_we   = 1'b0;
               ex_mem_we  = 1'b0;
               mem_wb_bub = 1'b1;
               wait_cnt_d = wait_cnt_q + 8'd1;
               if (wait_cnt_q == TIMEOUT_VAL) begin
                  state_d = ERR;
               end
            end else begin
               wait_cnt_d = 8'd0;
               if (branch_taken) begin
                  if_id_fl  = 1'b1;
                  id_ex_bub = 1'b1;
                  state_d   = RUN;
               end else if (load_use_hazard) begin
                  pc_we     = 1'b0;
                  if_id_we  = 1'b0;
                  id_ex_bub = 1'b1;
                  state_d   = LOAD_STALL;
               end else begin
                  state_d = RUN;
               end
            end
         end

         ERR: begin
            pc_we      = 1'b0;
            if_id_we   = 1'b0;
            ex_mem_we  = 1'b0;
            mem_wb_bub = 1'b1;
            terr       = 1'b1;
         end

         default: begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= RUN;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Every control output is forced low for as long as reset is held.
   assign pc_write_en     = arst_n & pc_we;
   assign if_id_write_en  = arst_n & if_id_we;
   assign if_id_flush     = arst_n & if_id_fl;
   assign id_ex_bubble    = arst_n & id_ex_bub;
   assign ex_mem_write_en = arst_n & ex_mem_we;
   assign mem_wb_bubble   = arst_n & mem_wb_bub;
   assign stall_active    = arst_n & ~pc_we;
   assign timeout_err     = arst_n & terr;

`ifdef STALL_PERF_CNT_EN
   logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_active && (stall_cnt_q != {PERF_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: MEM_WAIT cycles allowed before timeout; legal range 2..255.
REQ-002 SHALL have parameter PERF_W, default 16: width of stall_cycles.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 arst_n  input  1  asynchronous active-low reset.
REQ-006 load_use_hazard  input  1  load-use hazard flag from the hazard detection logic.
REQ-007 branch_taken  input  1  taken branch/jump resolved in EX/MEM.
REQ-008 dmem_req  input  1  MEM-stage instruction accesses data memory this cycle.
REQ-009 dmem_ack  input  1  data memory completes the access this cycle.
REQ-010 pc_write_en  output  1  PC update enable.
REQ-011 if_id_write_en  output  1  IF/ID register write enable.
REQ-012 if_id_flush  output  1  clear IF/ID to NOP.
REQ-013 id_ex_bubble  output  1  zero all ID/EX control bits.
REQ-014 ex_mem_write_en  output  1  EX/MEM register write enable.
REQ-015 mem_wb_bubble  output  1  zero MEM/WB control bits.
REQ-016 stall_active  output  1  high when pc_write_en is 0 for any reason.
REQ-017 timeout_err  output  1  sticky memory timeout flag.
REQ-018 stall_cycles  output  PERF_W  stall cycle count.

Function
REQ-019 SHALL have states RUN, LOAD_STALL, MEM_WAIT, ERR; outputs are combinational from state and inputs, and the wait counter (8 bit) is registered.
REQ-020 Default outputs: all write enables 1; flush and bubble 0.
REQ-021 RUN, priority 1: if dmem_req=1 and dmem_ack=0, SHALL drive all enables 0 and mem_wb_bubble=1, load wait counter to 1, and go to MEM_WAIT.
REQ-022 RUN, priority 2: if branch_taken=1, SHALL drive if_id_flush=1 and id_ex_bubble=1 with pc_write_en=1, and stay in RUN.
REQ-023 RUN, priority 3: if load_use_hazard=1, SHALL drive pc_write_en=0, if_id_write_en=0 and id_ex_bubble=1, and go to LOAD_STALL.
REQ-024 LOAD_STALL SHALL ignore load_use_hazard, drive default outputs, and return to RUN.
REQ-025 LOAD_STALL SHALL apply the priority 1 (memory) and priority 2 (branch) rules of RUN, with the same transitions.
REQ-026 MEM_WAIT, dmem_ack=0: SHALL drive the same freeze outputs as REQ-021 and increment the counter.
REQ-027 MEM_WAIT, dmem_ack=0 with counter equal to TIMEOUT_CYCLES: SHALL go to ERR.
REQ-028 MEM_WAIT, dmem_ack=1: SHALL release the freeze in that same cycle, evaluate the branch and load-use rules as in RUN, and leave to LOAD_STALL or RUN.
REQ-029 ERR SHALL hold the freeze outputs and timeout_err=1 indefinitely; the only exit is reset.
REQ-030 dmem_req and dmem_ack both 1 in RUN is a single-cycle access and SHALL cause no stall.
REQ-031 Simultaneous branch_taken and load_use_hazard: the flush wins, no stall is applied, and the next state is RUN.
REQ-032 stall_active SHALL equal the inverse of pc_write_en.

Reset
REQ-033 While arst_n=0: state=RUN, wait counter=0, stall_cycles=0, timeout_err=0.
REQ-034 While arst_n=0, all enables, flush and bubble outputs SHALL be 0 and stall_active SHALL be 0.
REQ-035 Reset asserted mid-MEM_WAIT or in ERR SHALL abandon the wait immediately; no pending state survives.
REQ-036 After deassertion, the first clock edge SHALL operate from RUN.

Configuration
REQ-037 With macro STALL_PERF_CNT_EN defined, stall_cycles SHALL increment on each clock edge where stall_active=1, saturating at all-ones.
REQ-038 Without STALL_PERF_CNT_EN, stall_cycles SHALL be tied to 0 with no counter logic; the port remains present.

Verification
REQ-039 Load-use hazard pulse for 1 cycle in RUN -> exactly 1 cycle of pc_write_en=0 and id_ex_bubble=1, then LOAD_STALL, then RUN.
REQ-040 load_use_hazard held at 1 for 3 cycles -> stalls alternate 1,0,1.
REQ-041 dmem_req=1 with dmem_ack after 5 cycles -> 5 frozen cycles; release in the ack cycle; stall_cycles=5 with the macro defined.
REQ-042 dmem_req=1 with no ack, TIMEOUT_CYCLES=4 -> ERR entered after cycle 4; timeout_err stays 1 until arst_n pulses low.
REQ-043 branch_taken and load_use_hazard in the same cycle -> if_id_flush=1, pc_write_en=1, next state RUN.
REQ-044 arst_n dropped in cycle 2 of MEM_WAIT -> all outputs 0 immediately; RUN with default outputs after release.
